i2c_stepper_regctrl: RTL and testbench

Register-file controller behind the I2C slave of the stepper-motor design. It turns slave byte events into register writes and reads using a byte pointer that auto-increments, and it supplies the transmit byte for master reads. It also sequences a step/direction generator from the programmed step count and period. This is the only block that configures motor motion from the I2C bus.

---
 rtl/i2c_stepper_regctrl_if.sv | 20 ++
 rtl/i2c_stepper_regctrl.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_stepper_regctrl.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_stepper_regctrl_if.sv
// Byte-event bus between the I2C slave front end and the stepper register controller.
// The master side is the slave PHY (drives events); the slave side is the register file.
`timescale 1ns/1ps
interface i2c_stepper_regctrl_if;
   logic       i2c_adr_match;
   logic       i2c_rnw;
   logic [7:0] i2c_dat;
   logic       i2c_dat_vld;
   logic [7:0] i2c_tx_byte;

   modport master (
      output i2c_adr_match, i2c_rnw, i2c_dat, i2c_dat_vld,
      input  i2c_tx_byte
   );

   modport slave (
      input  i2c_adr_match, i2c_rnw, i2c_dat, i2c_dat_vld,
      output i2c_tx_byte
   );
endinterface

// File: rtl/i2c_stepper_regctrl.sv
// Register file behind the I2C slave with an auto-incrementing byte pointer,
// plus the step/direction sequencer driven by the programmed step count and period.
`timescale 1ns/1ps
module i2c_stepper_regctrl #(
   parameter int unsigned PRESCALE = 1000,
   parameter logic [7:0]  DEV_ID   = 8'h5A
) (
   input  logic                  system1000,
   input  logic                  system1000_rstn,
   i2c_stepper_regctrl_if.slave  bus,
   output logic                  step_out,
   output logic                  dir_out,
   output logic                  busy
);
   localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {T_IDLE, T_PTR, T_DATA} txn_t;
   typedef enum logic [1:0] {M_IDLE, M_HIGH, M_LOW} mot_t;

   txn_t          txn_reg, txn_next;
   mot_t          mot_reg, mot_next;
   logic [2:0]    ptr_reg, ptr_next;
   logic          ctrl_en_reg, ctrl_en_next;
   logic          ctrl_dir_reg, ctrl_dir_next;
   logic [7:0]    steps_lo_reg, steps_lo_next;
   logic [7:0]    steps_hi_reg, steps_hi_next;
   logic [7:0]    period_reg, period_next;
   logic [15:0]   pos_reg, pos_next;
   logic          done_reg, done_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [7:0]    low_cnt_reg, low_cnt_next;
   logic [15:0]   steps_left_reg, steps_left_next;
   logic [7:0]    per_reg, per_next;
   logic          dir_out_reg, dir_out_next;
   logic [7:0]    tx_byte_reg, tx_byte_next;
   logic          tick;
   logic          wr_en;
   logic          ctrl_wr;

   always_comb begin
      txn_next        = txn_reg;
      mot_next        = mot_reg;
      ptr_next        = ptr_reg;
      ctrl_en_next    = ctrl_en_reg;
      ctrl_dir_next   = ctrl_dir_reg;
      steps_lo_next   = steps_lo_reg;
      steps_hi_next   = steps_hi_reg;
      period_next     = period_reg;
      pos_next        = pos_reg;
      done_next       = done_reg;
      presc_next      = presc_reg;
      low_cnt_next    = low_cnt_reg;
      steps_left_next = steps_left_reg;
      per_next        = per_reg;
      dir_out_next    = dir_out_reg;
      tx_byte_next    = tx_byte_reg;
      wr_en           = 1'b0;
      tick            = (mot_reg != M_IDLE) && (presc_reg == PS_LAST);

      // Address phase outranks a coincident data byte, which is dropped.
      if (bus.i2c_adr_match) begin
         if (bus.i2c_rnw) begin
            ptr_next = ptr_reg + 3'd1;
            txn_next = T_IDLE;
            if (ptr_reg == 3'd4) done_next = 1'b0;
         end else begin
            txn_next = T_PTR;
         end
      end else if (bus.i2c_dat_vld) begin
         case (txn_reg)
            T_PTR: begin
               ptr_next = bus.i2c_dat[2:0];
               txn_next = T_DATA;
            end
            T_DATA: begin
               wr_en    = 1'b1;
               ptr_next = ptr_reg + 3'd1;
            end
            default: ;
         endcase
      end

      ctrl_wr = wr_en && (ptr_reg == 3'd0);
      if (wr_en) begin
         case (ptr_reg)
            3'd0: begin
               ctrl_en_next  = bus.i2c_dat[0];
               ctrl_dir_next = bus.i2c_dat[1];
            end
            3'd1:    steps_lo_next = bus.i2c_dat;
            3'd2:    steps_hi_next = bus.i2c_dat;
            3'd3:    period_next   = bus.i2c_dat;
            default: ;
         endcase
      end

      if (mot_reg != M_IDLE) presc_next = tick ? '0 : presc_reg + 1'b1;

      case (mot_reg)
         M_IDLE: begin
            if (ctrl_wr && bus.i2c_dat[2] && bus.i2c_dat[0]) begin
               steps_left_next = {steps_hi_reg, steps_lo_reg};
               per_next        = (period_reg < 8'd2) ? 8'd2 : period_reg;
               dir_out_next    = bus.i2c_dat[1];
               if ({steps_hi_reg, steps_lo_reg} == 16'd0) begin
                  done_next = 1'b1;
               end else begin
                  done_next  = 1'b0;
                  mot_next   = M_HIGH;
                  presc_next = '0;
               end
            end
         end
         M_HIGH: begin
            if (tick) begin
               mot_next        = M_LOW;
               low_cnt_next    = 8'd0;
               pos_next        = dir_out_reg ? pos_reg - 16'd1 : pos_reg + 16'd1;
               steps_left_next = steps_left_reg - 16'd1;
            end
         end
         M_LOW: begin
            // Low phase spans per-1 ticks; low_cnt counts ticks already spent.
            if (tick) begin
               if (low_cnt_reg == per_reg - 8'd2) begin
                  if (steps_left_reg != 16'd0) begin
                     mot_next = M_HIGH;
                  end else begin
                     mot_next  = M_IDLE;
                     done_next = 1'b1;
                  end
               end else begin
                  low_cnt_next = low_cnt_reg + 8'd1;
               end
            end
         end
         default: mot_next = M_IDLE;
      endcase

      if (ctrl_wr && !bus.i2c_dat[0] && (mot_reg != M_IDLE)) begin
         mot_next   = M_IDLE;
         done_next  = 1'b0;
         presc_next = '0;
      end

      case (ptr_reg)
         3'd0:    tx_byte_next = {6'd0, ctrl_dir_reg, ctrl_en_reg};
         3'd1:    tx_byte_next = steps_lo_reg;
         3'd2:    tx_byte_next = steps_hi_reg;
         3'd3:    tx_byte_next = period_reg;
         3'd4:    tx_byte_next = {6'd0, done_reg, (mot_reg != M_IDLE)};
         3'd5:    tx_byte_next = pos_reg[7:0];
         3'd6:    tx_byte_next = pos_reg[15:8];
         default: tx_byte_next = DEV_ID;
      endcase
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         txn_reg        <= T_IDLE;
         mot_reg        <= M_IDLE;
         ptr_reg        <= 3'd0;
         ctrl_en_reg    <= 1'b0;
         ctrl_dir_reg   <= 1'b0;
         steps_lo_reg   <= 8'd0;
         steps_hi_reg   <= 8'd0;
         period_reg     <= 8'd0;
         pos_reg        <= 16'd0;
         done_reg       <= 1'b0;
         presc_reg      <= '0;
         low_cnt_reg    <= 8'd0;
         steps_left_reg <= 16'd0;
         per_reg        <= 8'd0;
         dir_out_reg    <= 1'b0;
         tx_byte_reg    <= 8'h00;
      end else begin
         txn_reg        <= txn_next;
         mot_reg        <= mot_next;
         ptr_reg        <= ptr_next;
         ctrl_en_reg    <= ctrl_en_next;
         ctrl_dir_reg   <= ctrl_dir_next;
         steps_lo_reg   <= steps_lo_next;
         steps_hi_reg   <= steps_hi_next;
         period_reg     <= period_next;
         pos_reg        <= pos_next;
         done_reg       <= done_next;
         presc_reg      <= presc_next;
         low_cnt_reg    <= low_cnt_next;
         steps_left_reg <= steps_left_next;
         per_reg        <= per_next;
         dir_out_reg    <= dir_out_next;
         tx_byte_reg    <= tx_byte_next;
      end
   end

   assign busy            = (mot_reg != M_IDLE);
   assign step_out        = (mot_reg == M_HIGH);
   assign dir_out         = dir_out_reg;
   assign bus.i2c_tx_byte = tx_byte_reg;
endmodule

// File: tb/tb_i2c_stepper_regctrl.sv
// Randomized bench for the stepper register controller; expectations come from a
// register-map model and closed-form step timing (pulse k rises k*per*PRESCALE clocks after GO).
`timescale 1ns/1ps
module tb_i2c_stepper_regctrl;
   localparam int         P  = 4;
   localparam logic [7:0] ID = 8'h5A;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic step_out, dir_out, busy;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   i2c_stepper_regctrl_if bus();

   i2c_stepper_regctrl #(.PRESCALE(P), .DEV_ID(ID)) dut (
      .system1000      (clk),
      .system1000_rstn (rstn),
      .bus             (bus),
      .step_out        (step_out),
      .dir_out         (dir_out),
      .busy            (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: register map, pointer, transaction phase (0 idle, 1 pointer, 2 data).
   logic [7:0]  m_steps_lo, m_steps_hi, m_period;
   logic        m_en, m_dir, m_dirout, m_busy, m_done;
   logic [15:0] m_pos;
   logic [2:0]  m_ptr;
   int          m_phase, m_steps, m_per;

   function automatic logic [7:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {6'd0, m_dir, m_en};
         3'd1:    return m_steps_lo;
         3'd2:    return m_steps_hi;
         3'd3:    return m_period;
         3'd4:    return {6'd0, m_done, m_busy};
         3'd5:    return m_pos[7:0];
         3'd6:    return m_pos[15:8];
         default: return ID;
      endcase
   endfunction

   task automatic m_reset();
      m_steps_lo = 0; m_steps_hi = 0; m_period = 0;
      m_en = 0; m_dir = 0; m_dirout = 0; m_busy = 0; m_done = 0;
      m_pos = 0; m_ptr = 0; m_phase = 0; m_steps = 0; m_per = 2;
   endtask

   task automatic m_dat(input logic [7:0] d);
      if (m_phase == 1) begin
         m_ptr   = d[2:0];
         m_phase = 2;
      end else if (m_phase == 2) begin
         case (m_ptr)
            3'd0: begin
               m_en  = d[0];
               m_dir = d[1];
               if (d[2] && d[0] && !m_busy) begin
                  m_steps  = {m_steps_hi, m_steps_lo};
                  m_per    = (m_period < 2) ? 2 : int'(m_period);
                  m_dirout = d[1];
                  if (m_steps == 0) m_done = 1;
                  else begin m_busy = 1; m_done = 0; end
               end else if (!d[0] && m_busy) begin
                  m_busy = 0;
                  m_done = 0;
               end
            end
            3'd1:    m_steps_lo = d;
            3'd2:    m_steps_hi = d;
            3'd3:    m_period   = d;
            default: ;
         endcase
         m_ptr = m_ptr + 3'd1;
      end
   endtask

   // Bus drivers: all are entered and left 1 ns after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   task automatic ev_adr(input logic rnw, output logic [7:0] got);
      bus.i2c_adr_match = 1'b1;
      bus.i2c_rnw       = rnw;
      got               = bus.i2c_tx_byte;
      @(posedge clk); #1;
      bus.i2c_adr_match = 1'b0;
      bus.i2c_rnw       = 1'b0;
   endtask

   task automatic ev_dat(input logic [7:0] d);
      bus.i2c_dat_vld = 1'b1;
      bus.i2c_dat     = d;
      @(posedge clk); #1;
      bus.i2c_dat_vld = 1'b0;
      bus.i2c_dat     = 8'h00;
   endtask

   task automatic wr_ptr(input logic [2:0] p);
      logic [7:0] tmp;
      logic [7:0] d;
      ev_adr(1'b0, tmp);
      m_phase = 1;
      idle(2);
      d      = 8'($urandom);
      d[2:0] = p;
      ev_dat(d);
      m_dat(d);
      idle(2);
   endtask

   task automatic wr_byte(input logic [7:0] d);
      ev_dat(d);
      m_dat(d);
      idle(2);
   endtask

   task automatic rd(output logic [7:0] got);
      logic [2:0] p;
      p = m_ptr;
      ev_adr(1'b1, got);
      if (m_ptr == 3'd4) m_done = 0;
      m_ptr   = m_ptr + 3'd1;
      m_phase = 0;
      $display("read ptr=%0d tx_byte=%h", p, got);
      idle(2);
   endtask

   task automatic test_reset();
      logic [7:0] got, exp;
      @(posedge clk); #1;
      checks++;
      if ({step_out, dir_out, busy, bus.i2c_tx_byte} !== 11'd0) begin
         errors++;
         $display("FAIL reset_held: step/dir/busy/tx=%b/%b/%b/%h, expected 0/0/0/00",
                  step_out, dir_out, busy, bus.i2c_tx_byte);
      end
      idle(2);
      rstn = 1'b1;
      m_reset();
      idle(2);
      checks++;
      if ({step_out, dir_out, busy, bus.i2c_tx_byte} !== 11'd0) begin
         errors++;
         $display("FAIL reset_release: step/dir/busy/tx=%b/%b/%b/%h, expected 0/0/0/00",
                  step_out, dir_out, busy, bus.i2c_tx_byte);
      end
      wr_ptr(3'd4);
      exp = m_read(m_ptr);
      rd(got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_status: got %h expected %h", got, exp);
      end
   endtask

   task automatic test_motion();
      for (int r = 0; r < 6; r++) begin
         int         steps, per_raw, total, bad, bad_i;
         logic       dir, exp_s, exp_b;
         logic [7:0] d, got, exp;
         logic [2:0] obs;
         if (r < 2) begin
            steps = 3; per_raw = 2; dir = (r == 1);
         end else begin
            steps = $urandom_range(1, 4); per_raw = $urandom_range(0, 4); dir = 1'($urandom_range(0, 1));
         end
         wr_ptr(3'd1);
         wr_byte(8'(steps));
         wr_byte(8'(steps >> 8));
         wr_byte(8'(per_raw));
         exp = m_read(m_ptr);
         rd(got);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL motion_pre_status run%0d: got %h expected %h", r, got, exp);
         end
         wr_ptr(3'd0);
         d = (8'($urandom) & 8'hF8) | {5'd0, 1'b1, dir, 1'b1};
         ev_dat(d);
         m_dat(d);
         total = m_steps * m_per * P;
         bad   = 0;
         bad_i = 0;
         obs   = 3'b000;
         for (int i = 0; i < total + 4; i++) begin
            exp_s = (i < total) && ((i % (m_per * P)) < P);
            exp_b = (i < total);
            if (step_out !== exp_s || busy !== exp_b || dir_out !== m_dirout) begin
               if (bad == 0) begin bad_i = i; obs = {step_out, busy, dir_out}; end
               bad++;
            end
            idle(1);
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL motion_wave run%0d: %0d bad cycles, first at %0d step/busy/dir=%b, expected %b%b%b",
                     r, bad, bad_i, obs, (bad_i < total) && ((bad_i % (m_per * P)) < P),
                     bad_i < total, m_dirout);
         end
         m_pos  = m_dirout ? m_pos - 16'(m_steps) : m_pos + 16'(m_steps);
         m_busy = 0;
         m_done = 1;
         wr_ptr(3'd4);
         for (int k = 0; k < 3; k++) begin
            exp = m_read(m_ptr);
            rd(got);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL motion_post run%0d reg%0d: got %h expected %h", r, 4 + k, got, exp);
            end
         end
      end
   endtask

   task automatic test_zero_steps();
      logic [7:0] got, exp;
      int bad;
      wr_ptr(3'd1);
      wr_byte(8'h00);
      wr_byte(8'h00);
      wr_ptr(3'd0);
      ev_dat(8'h05);
      m_dat(8'h05);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (step_out !== 1'b0 || busy !== 1'b0) bad++;
         idle(1);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL zero_steps_idle: %0d cycles with step_out/busy set, expected 0", bad);
      end
      for (int k = 0; k < 2; k++) begin
         wr_ptr(3'd4);
         exp = m_read(m_ptr);
         rd(got);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL zero_steps_status read%0d: got %h expected %h", k, got, exp);
         end
      end
      wr_ptr(3'd0);
      exp = m_read(m_ptr);
      rd(got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL ctrl_go_reads_zero: got %h expected %h", got, exp);
      end
   endtask

   task automatic test_abort();
      logic [7:0] got, exp, tmp;
      int t0, bad;
      wr_ptr(3'd1);
      wr_byte(8'd100);
      wr_byte(8'd0);
      wr_byte(8'd2);
      wr_ptr(3'd0);
      ev_dat(8'h05);
      m_dat(8'h05);
      t0 = cyc;
      wait_cyc(t0 + 1); ev_adr(1'b0, tmp); m_phase = 1;
      wait_cyc(t0 + 3); ev_dat(8'h00); m_dat(8'h00);
      wait_cyc(t0 + 5); ev_dat(8'h05); m_dat(8'h05);
      checks++;
      if (busy !== 1'b1 || step_out !== 1'b0) begin
         errors++;
         $display("FAIL go_while_busy: busy/step=%b/%b, expected 1/0", busy, step_out);
      end
      wait_cyc(t0 + 7); ev_adr(1'b0, tmp); m_phase = 1;
      wait_cyc(t0 + 9); ev_dat(8'h00); m_dat(8'h00);
      wait_cyc(t0 + 16);
      checks++;
      if (step_out !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_third_pulse: step/busy=%b/%b, expected 1/1", step_out, busy);
      end
      m_pos = m_pos + 16'((17 - P) / (m_per * P) + 1);
      ev_dat(8'h00);
      m_dat(8'h00);
      checks++;
      if (step_out !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_stop: step/busy=%b/%b, expected 0/0", step_out, busy);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (step_out !== 1'b0 || busy !== 1'b0) bad++;
         idle(1);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL abort_stays_idle: %0d active cycles, expected 0", bad);
      end
      wr_ptr(3'd4);
      for (int k = 0; k < 3; k++) begin
         exp = m_read(m_ptr);
         rd(got);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL abort_post reg%0d: got %h expected %h", 4 + k, got, exp);
         end
      end
   endtask

   task automatic test_id_wrap_ro();
      logic [7:0] got, exp;
      wr_ptr(3'd7);
      for (int k = 0; k < 2; k++) begin
         exp = m_read(m_ptr);
         rd(got);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL id_wrap read%0d: got %h expected %h", k, got, exp);
         end
      end
      wr_ptr(3'd4);
      wr_byte(8'hFF);
      wr_byte(8'hFF);
      wr_byte(8'hFF);
      wr_byte(8'hAA);
      wr_ptr(3'd4);
      for (int k = 0; k < 4; k++) begin
         exp = m_read(m_ptr);
         rd(got);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL ro_write_dropped reg%0d: got %h expected %h", (4 + k) % 8, got, exp);
         end
      end
   endtask

   task automatic test_regs_random();
      logic [7:0] got, exp, d;
      int nb;
      for (int it = 0; it < 10; it++) begin
         wr_ptr(3'($urandom_range(0, 7)));
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            d = 8'($urandom);
            if (m_ptr == 3'd0) d[2] = 1'b0;
            wr_byte(d);
         end
      end
      exp = m_read(m_ptr);
      rd(got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL random_read: got %h expected %h", got, exp);
      end
      d = 8'($urandom);
      ev_dat(d);
      m_dat(d);
      idle(2);
      wr_ptr(3'd1);
      d = 8'($urandom);
      bus.i2c_adr_match = 1'b1;
      bus.i2c_rnw       = 1'b0;
      bus.i2c_dat_vld   = 1'b1;
      bus.i2c_dat       = d;
      @(posedge clk); #1;
      bus.i2c_adr_match = 1'b0;
      bus.i2c_dat_vld   = 1'b0;
      bus.i2c_dat       = 8'h00;
      m_phase = 1;
      idle(2);
      wr_byte(8'h03);
      wr_byte(8'($urandom));
      wr_ptr(3'd0);
      for (int k = 0; k < 8; k++) begin
         exp = m_read(m_ptr);
         rd(got);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random_regs reg%0d: got %h expected %h", k, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got, exp;
      wr_ptr(3'd1);
      wr_byte(8'd100);
      wr_byte(8'd0);
      wr_byte(8'd3);
      wr_ptr(3'd1);
      wr_ptr(3'd0);
      ev_dat(8'h07);
      m_dat(8'h07);
      idle(1);
      checks++;
      if (step_out !== 1'b1 || busy !== 1'b1 || dir_out !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_motion: step/busy/dir=%b/%b/%b, expected 1/1/1", step_out, busy, dir_out);
      end
      #3 rstn = 1'b0;
      #1;
      checks++;
      if ({step_out, dir_out, busy, bus.i2c_tx_byte} !== 11'd0) begin
         errors++;
         $display("FAIL async_reset: step/dir/busy/tx=%b/%b/%b/%h, expected 0/0/0/00",
                  step_out, dir_out, busy, bus.i2c_tx_byte);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      m_reset();
      idle(2);
      wr_ptr(3'd0);
      for (int k = 0; k < 8; k++) begin
         exp = m_read(m_ptr);
         rd(got);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL after_reset reg%0d: got %h expected %h", k, got, exp);
         end
      end
   endtask

   initial begin
      bus.i2c_adr_match = 1'b0;
      bus.i2c_rnw       = 1'b0;
      bus.i2c_dat       = 8'h00;
      bus.i2c_dat_vld   = 1'b0;
      m_reset();
      test_reset();
      test_motion();
      test_zero_steps();
      test_abort();
      test_id_wrap_ro();
      test_regs_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
